// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI bus pins plus TX/RX byte handshake. Master drives sclk, ss_n, mosi, tx_data and tx_valid; the slave drives everything else.
interface spi_slave_if;
  logic       sclk;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       tx_underrun;
  logic       frame_abort;
  modport master (
    output sclk, ss_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_abort
  );
  modport slave (
    input  sclk, ss_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, frame_abort
  );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: Mode 0 SPI target (8-bit MSB first) with oversampled inputs; ports clk, rst, bus (spi_slave_if.slave).
module spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEFAULT_TX  = 8'hFF
) (
  input logic         clk,
  input logic         rst,
  spi_slave_if.slave  bus
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES:0]   sclk_q, ss_q, fill_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   armed_q;
  logic [7:0]             buf_q, sh_tx_q, rx_data_q;
  logic [6:0]             sh_rx_q;
  logic [2:0]             bit_cnt_q;
  logic                   buf_full_q, from_buf_q, boundary_q;
  logic                   rx_valid_q, tx_underrun_q, frame_abort_q;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic                   start, stop, rise_s, fall_s, load, commit, last_bit;
  logic [7:0]             rx_next;
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign ss_rise   = ss_q[SYNC_STAGES-1] & ~ss_q[SYNC_STAGES];
  assign ss_fall   = ~ss_q[SYNC_STAGES-1] & ss_q[SYNC_STAGES];
  assign start     = state_q == IDLE && state_d == SHIFT;
  assign stop      = state_q == SHIFT && ss_rise;
  // ss_n rising wins over any SCLK edge seen in the same cycle
  assign rise_s    = state_q == SHIFT && !ss_rise && sclk_rise;
  assign fall_s    = state_q == SHIFT && !ss_rise && sclk_fall;
  assign load      = start | (fall_s & boundary_q);
  assign commit    = rise_s && bit_cnt_q == 3'd7;
  assign last_bit  = rise_s && bit_cnt_q == 3'd0;
  assign rx_next   = {sh_rx_q, mosi_q[SYNC_STAGES-1]};
  assign bus.tx_ready    = ~buf_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.frame_abort = frame_abort_q;
  // fill_q marks when the sync chain holds real samples rather than reset
  // values, so a select already low at reset release can never arm a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      ss_q   <= '1;
      mosi_q <= '0;
      fill_q <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], bus.sclk};
      ss_q   <= {ss_q[SYNC_STAGES-1:0], bus.ss_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = ss_fall && armed_q ? SHIFT : IDLE;
    else                 state_d = ss_rise ? IDLE : SHIFT;
  end
  always_comb begin
    bus.busy    = state_q == SHIFT;
    bus.miso_oe = state_q == SHIFT;
    bus.miso    = state_q == SHIFT && sh_tx_q[7];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q       <= 1'b0;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      sh_tx_q       <= '0;
      from_buf_q    <= 1'b0;
      sh_rx_q       <= '0;
      bit_cnt_q     <= 3'd7;
      boundary_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      armed_q       <= armed_q | (fill_q[SYNC_STAGES] & ss_q[SYNC_STAGES-1]);
      rx_valid_q    <= last_bit;
      tx_underrun_q <= commit & ~from_buf_q;
      frame_abort_q <= stop && bit_cnt_q != 3'd7;
      // writes only land in an empty buffer, so a pop never collides with one
      if (bus.tx_valid && !buf_full_q) begin
        buf_q      <= bus.tx_data;
        buf_full_q <= 1'b1;
      end else if (commit && from_buf_q) begin
        buf_full_q <= 1'b0;
      end
      // loading only peeks; the buffer is popped later at the slot's first rise
      if (load) begin
        sh_tx_q    <= buf_full_q ? buf_q : DEFAULT_TX;
        from_buf_q <= buf_full_q;
      end else if (fall_s) begin
        sh_tx_q    <= {sh_tx_q[6:0], 1'b0};
      end
      sh_rx_q    <= start ? '0 : rise_s ? rx_next[6:0] : sh_rx_q;
      bit_cnt_q  <= start || stop || last_bit ? 3'd7 : rise_s ? bit_cnt_q - 3'd1 : bit_cnt_q;
      boundary_q <= start || stop ? 1'b0 : last_bit ? 1'b1 : fall_s ? 1'b0 : boundary_q;
      if (last_bit) rx_data_q <= rx_next;
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: bit-level Mode 0 master driving spi_slave, checked against a per-slot buffer model.
module tb_spi_slave;
  localparam int H = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_slave_if bus();
  spi_slave #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int n_rxv = 0;
  int n_und = 0;
  int n_abt = 0;
  logic [7:0] rx_log [256];
  logic rdy_mid;
  logic [7:0] model_rx = 8'h00;
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rx_log[n_rxv % 256] = bus.rx_data;
      n_rxv++;
    end
    if (bus.tx_underrun === 1'b1) n_und++;
    if (bus.frame_abort === 1'b1) n_abt++;
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic write_buf(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask
  task automatic sel();
    bus.ss_n = 1'b0;
    clks(2 * H);
  endtask
  task automatic desel();
    clks(H);
    bus.ss_n = 1'b1;
    clks(2 * H);
  endtask
  task automatic xfer(input logic [7:0] mo, input int nbits, input logic do_wr, input logic [7:0] wd, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = mo[7-i];
      clks(H);
      bus.sclk = 1'b1;
      mi[7-i] = bus.miso;
      if (i == 3) rdy_mid = bus.tx_ready;
      if (do_wr && i == 3) begin
        write_buf(wd);
        clks(H - 1);
      end else clks(H);
      bus.sclk = 1'b0;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    clks(4);
    rst = 1'b0;
    clks(1);
    checks++; if (bus.miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", bus.miso); end
    checks++; if (bus.miso_oe !== 1'b0) begin errors++; $display("FAIL reset_miso_oe: got %b want 0", bus.miso_oe); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", bus.tx_ready); end
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
    checks++; if ({bus.rx_valid, bus.busy, bus.tx_underrun, bus.frame_abort} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {bus.rx_valid, bus.busy, bus.tx_underrun, bus.frame_abort}); end
    model_rx = 8'h00;
    clks(2 * H);
  endtask
  task automatic test_single();
    int r0, u0;
    logic [7:0] g;
    r0 = n_rxv; u0 = n_und;
    write_buf(8'hA5);
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL single_full: got %b want 0", bus.tx_ready); end
    sel();
    xfer(8'h3C, 8, 1'b0, 8'h00, g);
    desel();
    model_rx = 8'h3C;
    checks++; if (g !== 8'hA5) begin errors++; $display("FAIL single_miso: got %h want a5", g); end
    checks++; if (bus.rx_data !== 8'h3C) begin errors++; $display("FAIL single_rx: got %h want 3c", bus.rx_data); end
    checks++; if (n_rxv - r0 !== 1) begin errors++; $display("FAIL single_rxv: got %0d want 1", n_rxv - r0); end
    checks++; if (rdy_mid !== 1'b1) begin errors++; $display("FAIL single_pop: got %b want 1", rdy_mid); end
    checks++; if (n_und - u0 !== 0) begin errors++; $display("FAIL single_und: got %0d want 0", n_und - u0); end
  endtask
  task automatic test_underrun();
    int u0;
    logic [7:0] g;
    u0 = n_und;
    sel();
    xfer(8'h81, 8, 1'b0, 8'h00, g);
    desel();
    model_rx = 8'h81;
    checks++; if (g !== 8'hFF) begin errors++; $display("FAIL under_miso: got %h want ff", g); end
    checks++; if (n_und - u0 !== 1) begin errors++; $display("FAIL under_cnt: got %0d want 1", n_und - u0); end
    checks++; if (bus.rx_data !== 8'h81) begin errors++; $display("FAIL under_rx: got %h want 81", bus.rx_data); end
  endtask
  task automatic test_back_to_back();
    int r0, u0;
    logic [7:0] g0, g1;
    r0 = n_rxv; u0 = n_und;
    write_buf(8'h11);
    sel();
    xfer(8'hAA, 8, 1'b1, 8'h22, g0);
    xfer(8'h55, 8, 1'b0, 8'h00, g1);
    desel();
    model_rx = 8'h55;
    checks++; if (g0 !== 8'h11) begin errors++; $display("FAIL b2b_byte0: got %h want 11", g0); end
    checks++; if (g1 !== 8'h22) begin errors++; $display("FAIL b2b_byte1: got %h want 22", g1); end
    checks++; if (n_rxv - r0 !== 2) begin errors++; $display("FAIL b2b_rxv: got %0d want 2", n_rxv - r0); end
    checks++; if (rx_log[(n_rxv - 2) % 256] !== 8'hAA) begin errors++; $display("FAIL b2b_rx0: got %h want aa", rx_log[(n_rxv - 2) % 256]); end
    checks++; if (bus.rx_data !== 8'h55) begin errors++; $display("FAIL b2b_rx1: got %h want 55", bus.rx_data); end
    checks++; if (n_und - u0 !== 0) begin errors++; $display("FAIL b2b_und: got %0d want 0", n_und - u0); end
  endtask
  task automatic test_abort();
    int r0, a0;
    logic [7:0] g;
    r0 = n_rxv; a0 = n_abt;
    write_buf(8'h77);
    sel();
    xfer(8'hC3, 5, 1'b0, 8'h00, g);
    desel();
    checks++; if (n_abt - a0 !== 1) begin errors++; $display("FAIL abort_cnt: got %0d want 1", n_abt - a0); end
    checks++; if (n_rxv - r0 !== 0) begin errors++; $display("FAIL abort_rxv: got %0d want 0", n_rxv - r0); end
    checks++; if (bus.rx_data !== model_rx) begin errors++; $display("FAIL abort_rx: got %h want %h", bus.rx_data, model_rx); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL abort_pop: got %b want 1", bus.tx_ready); end
    checks++; if (g[7:3] !== 5'b01110) begin errors++; $display("FAIL abort_miso: got %b want 01110", g[7:3]); end
  endtask
  task automatic test_keep();
    int u0;
    logic [7:0] g, g2;
    u0 = n_und;
    write_buf(8'hA5);
    sel();
    xfer(8'h12, 8, 1'b1, 8'h5A, g);
    desel();
    checks++; if (g !== 8'hA5) begin errors++; $display("FAIL keep_first: got %h want a5", g); end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL keep_held: got %b want 0", bus.tx_ready); end
    sel();
    xfer(8'h34, 8, 1'b0, 8'h00, g2);
    desel();
    model_rx = 8'h34;
    checks++; if (g2 !== 8'h5A) begin errors++; $display("FAIL keep_second: got %h want 5a", g2); end
    checks++; if (n_und - u0 !== 0) begin errors++; $display("FAIL keep_und: got %0d want 0", n_und - u0); end
  endtask
  task automatic test_reset_mid();
    int r0, a0, u0;
    logic [7:0] g;
    write_buf(8'h99);
    sel();
    xfer(8'hF0, 3, 1'b0, 8'h00, g);
    r0 = n_rxv; a0 = n_abt; u0 = n_und;
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    clks(1);
    model_rx = 8'h00;
    checks++; if ({bus.busy, bus.miso_oe, bus.miso} !== 3'b000) begin errors++; $display("FAIL rstmid_out: got %b want 000", {bus.busy, bus.miso_oe, bus.miso}); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", bus.tx_ready); end
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx: got %h want 00", bus.rx_data); end
    xfer(8'hFF, 8, 1'b0, 8'h00, g);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_noshift: got %b want 0", bus.busy); end
    checks++; if (n_rxv - r0 !== 0) begin errors++; $display("FAIL rstmid_rxv: got %0d want 0", n_rxv - r0); end
    desel();
    sel();
    xfer(8'h6B, 8, 1'b0, 8'h00, g);
    desel();
    model_rx = 8'h6B;
    checks++; if (g !== 8'hFF) begin errors++; $display("FAIL rstmid_miso: got %h want ff", g); end
    checks++; if (bus.rx_data !== 8'h6B) begin errors++; $display("FAIL rstmid_next: got %h want 6b", bus.rx_data); end
    checks++; if (n_abt - a0 !== 0) begin errors++; $display("FAIL rstmid_abort: got %0d want 0", n_abt - a0); end
    checks++; if (n_und - u0 !== 1) begin errors++; $display("FAIL rstmid_und: got %0d want 1", n_und - u0); end
  endtask
  task automatic test_random();
    logic [7:0] mo [4];
    logic [7:0] wd [4];
    logic       wv [4];
    logic [7:0] g, exp_b;
    int n, r0, u0, miss;
    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(1, 3);
      miss = 0;
      for (int k = 0; k < 4; k++) begin
        mo[k] = 8'($urandom);
        wd[k] = 8'($urandom);
        wv[k] = 1'($urandom_range(0, 1));
      end
      for (int k = 0; k < n; k++) if (!wv[k]) miss++;
      r0 = n_rxv; u0 = n_und;
      if (wv[0]) begin
        checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL rand_ready_pre f%0d: got %b want 1", f, bus.tx_ready); end
        write_buf(wd[0]);
      end
      sel();
      for (int k = 0; k < n; k++) begin
        xfer(mo[k], 8, k < n - 1 && wv[k+1], wd[k+1], g);
        exp_b = wv[k] ? wd[k] : 8'hFF;
        checks++; if (g !== exp_b) begin errors++; $display("FAIL rand_miso f%0d b%0d: got %h want %h", f, k, g, exp_b); end
        if (k < n - 1 && wv[k+1]) begin
          checks++; if (rdy_mid !== 1'b1) begin errors++; $display("FAIL rand_ready f%0d b%0d: got %b want 1", f, k, rdy_mid); end
        end
      end
      desel();
      model_rx = mo[n-1];
      checks++; if (n_rxv - r0 !== n) begin errors++; $display("FAIL rand_rxv f%0d: got %0d want %0d", f, n_rxv - r0, n); end
      else for (int k = 0; k < n; k++) begin
        checks++; if (rx_log[(r0 + k) % 256] !== mo[k]) begin errors++; $display("FAIL rand_rx f%0d b%0d: got %h want %h", f, k, rx_log[(r0 + k) % 256], mo[k]); end
      end
      checks++; if (n_und - u0 !== miss) begin errors++; $display("FAIL rand_und f%0d: got %0d want %0d", f, n_und - u0, miss); end
    end
  endtask
  initial begin
    bus.sclk = 1'b0;
    bus.ss_n = 1'b1;
    bus.mosi = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    test_reset();
    test_single();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_keep();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
